// File: rtl/mw_pkg.sv
// Shared types for the MEM->WB elastic stage: writeback payload layout and skid-buffer states.
package mw_pkg;

    localparam int MW_DATA_W = 32;
    localparam int MW_REG_W  = 5;
    localparam int MW_RSRC_W = 2;

    typedef struct packed {
        logic [MW_DATA_W-1:0] alu_result;
        logic [MW_DATA_W-1:0] read_data;
        logic [MW_DATA_W-1:0] pc_plus4;
        logic [MW_REG_W-1:0]  rd;
        logic                 reg_write;
        logic [MW_RSRC_W-1:0] result_src;
    } mw_payload_t;

    localparam int MW_PAYLOAD_W = $bits(mw_payload_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } mw_state_t;

endpackage

// File: rtl/mw_stage_elastic_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; main entry drives the outputs.
//   state | meaning
//   EMPTY | nothing held, out_valid=0
//   ONE   | main valid, skid free
//   FULL  | main and skid valid, in_ready=0
module skid_buffer
    import mw_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    mw_state_t        state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Handshake flags are pure decodes of the state register, so in_ready never depends on out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    case ({in_valid, out_ready})
                        2'b11: main_q <= in_data;
                        2'b01: state  <= EMPTY;
                        2'b10: begin
                            skid_q <= in_data;
                            state  <= FULL;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (out_ready) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/mw_stage_elastic.sv
// MEM->WB elastic pipeline stage: packs the writeback payload through a 2-entry skid buffer.
// Optional stall counter output enabled by defining MW_STALL_CNT_EN.
module mw_stage_elastic
    import mw_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int RESULT_SRC_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       alu_result_m,
    input  logic [DATA_WIDTH-1:0]       read_data_m,
    input  logic [DATA_WIDTH-1:0]       pc_plus4_m,
    input  logic [REG_ADDR_WIDTH-1:0]   rd_m,
    input  logic                        reg_write_m,
    input  logic [RESULT_SRC_WIDTH-1:0] result_src_m,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       alu_result_w,
    output logic [DATA_WIDTH-1:0]       read_data_w,
    output logic [DATA_WIDTH-1:0]       pc_plus4_w,
    output logic [REG_ADDR_WIDTH-1:0]   rd_w,
    output logic                        reg_write_w,
`ifdef MW_STALL_CNT_EN
    output logic [31:0]                 stall_cnt,
`endif
    output logic [RESULT_SRC_WIDTH-1:0] result_src_w
);

    localparam int PW = 3*DATA_WIDTH + REG_ADDR_WIDTH + 1 + RESULT_SRC_WIDTH;

    // Field order matches mw_payload_t, so at default parameters the vector is bit-identical to it.
    logic [PW-1:0] in_pl;
    logic [PW-1:0] out_pl;
    logic          reg_write_q;

    assign in_pl = {alu_result_m, read_data_m, pc_plus4_m, rd_m, reg_write_m, result_src_m};
    assign {alu_result_w, read_data_w, pc_plus4_w, rd_w, reg_write_q, result_src_w} = out_pl;

    assign reg_write_w = reg_write_q & out_valid;

    skid_buffer #(.WIDTH(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

`ifdef MW_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mw_stage_elastic.sv
// Self-checking bench for mw_stage_elastic: directed vector table plus randomized traffic vs a queue model.
module tb_mw_stage_elastic;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
    logic [31:0] alu_result_w, read_data_w, pc_plus4_w;
    logic [4:0]  rd_m, rd_w;
    logic        reg_write_m, reg_write_w;
    logic [1:0]  result_src_m, result_src_w;
`ifdef MW_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    mw_stage_elastic dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result_m (alu_result_m),
        .read_data_m  (read_data_m),
        .pc_plus4_m   (pc_plus4_m),
        .rd_m         (rd_m),
        .reg_write_m  (reg_write_m),
        .result_src_m (result_src_m),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_result_w (alu_result_w),
        .read_data_w  (read_data_w),
        .pc_plus4_w   (pc_plus4_w),
        .rd_w         (rd_w),
        .reg_write_w  (reg_write_w),
`ifdef MW_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .result_src_w (result_src_w)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rs;
    } pl_t;

    typedef struct packed {
        logic        rst, fl, iv, ordy;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        e_ov, e_ir, e_rw;
        logic [31:0] e_alu;
        logic [4:0]  e_rd;
        logic        zchk;
    } vec_t;

    int    checks   = 0;
    int    failures = 0;
    pl_t   q[$];
    logic [31:0] m_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic pl_t mkpl(input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        pl_t p;
        p.alu   = alu;
        p.rdata = alu ^ 32'hA5A5_5A5A;
        p.pc    = alu + 32'd4;
        p.rd    = rd;
        p.rw    = rw;
        p.rs    = rd[1:0];
        return p;
    endfunction

    // Drive one cycle of inputs, advance the FIFO model across the edge, then compare.
    task automatic cycle(input logic rst, input logic fl, input logic iv, input logic ordy, input pl_t p);
        bit acc, rel;
        rst_n        = rst;
        flush        = fl;
        in_valid     = iv;
        out_ready    = ordy;
        alu_result_m = p.alu;
        read_data_m  = p.rdata;
        pc_plus4_m   = p.pc;
        rd_m         = p.rd;
        reg_write_m  = p.rw;
        result_src_m = p.rs;
        acc = iv && (q.size() < 2);
        rel = (q.size() > 0) && ordy;
        if (!rst) begin
            q.delete();
            m_stall = 0;
        end else begin
            if (q.size() > 0 && !ordy) m_stall = m_stall + 32'd1;
            if (fl) q.delete();
            else begin
                if (rel) void'(q.pop_front());
                if (acc) q.push_back(p);
            end
        end
        @(posedge clk);
        #1;
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("m_reg_write_w", {31'd0, reg_write_w}, {31'd0, q[0].rw});
            chk("m_alu_result_w", alu_result_w, q[0].alu);
            chk("m_read_data_w", read_data_w, q[0].rdata);
            chk("m_pc_plus4_w", pc_plus4_w, q[0].pc);
            chk("m_rd_w", {27'd0, rd_w}, {27'd0, q[0].rd});
            chk("m_result_src_w", {30'd0, result_src_w}, {30'd0, q[0].rs});
        end else begin
            chk("m_reg_write_w_bubble", {31'd0, reg_write_w}, 32'd0);
        end
`ifdef MW_STALL_CNT_EN
        chk("m_stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    function automatic vec_t mkv(input logic rst, fl, iv, ordy, input logic [31:0] alu,
                                 input logic [4:0] rd, input logic rw,
                                 input logic e_ov, e_ir, e_rw, input logic [31:0] e_alu,
                                 input logic [4:0] e_rd, input logic zchk);
        vec_t v;
        v = '{rst, fl, iv, ordy, alu, rd, rw, e_ov, e_ir, e_rw, e_alu, e_rd, zchk};
        return v;
    endfunction

    vec_t tv[22];

    initial begin
        //            rst fl iv or  alu         rd  rw   ov ir rw  e_alu       e_rd zchk
        tv[0]  = mkv(0, 0, 1, 1, 32'h55, 5'd3,  1,  0, 1, 0, 32'h0,  5'd0,  1);
        tv[1]  = mkv(0, 0, 1, 1, 32'h55, 5'd3,  1,  0, 1, 0, 32'h0,  5'd0,  1);
        tv[2]  = mkv(0, 0, 1, 1, 32'h55, 5'd3,  1,  0, 1, 0, 32'h0,  5'd0,  1);
        tv[3]  = mkv(1, 0, 1, 1, 32'h10, 5'd1,  1,  1, 1, 1, 32'h10, 5'd1,  0);
        tv[4]  = mkv(1, 0, 1, 1, 32'h20, 5'd2,  1,  1, 1, 1, 32'h20, 5'd2,  0);
        tv[5]  = mkv(1, 0, 1, 1, 32'h30, 5'd3,  0,  1, 1, 0, 32'h30, 5'd3,  0);
        tv[6]  = mkv(1, 0, 0, 1, 32'h0,  5'd0,  0,  0, 1, 0, 32'h0,  5'd0,  0);
        tv[7]  = mkv(1, 0, 1, 0, 32'h50, 5'd5,  1,  1, 1, 1, 32'h50, 5'd5,  0);
        tv[8]  = mkv(1, 0, 1, 0, 32'h70, 5'd7,  1,  1, 0, 1, 32'h50, 5'd5,  0);
        tv[9]  = mkv(1, 0, 1, 0, 32'h99, 5'd9,  1,  1, 0, 1, 32'h50, 5'd5,  0);
        tv[10] = mkv(1, 0, 0, 1, 32'h0,  5'd0,  0,  1, 1, 1, 32'h70, 5'd7,  0);
        tv[11] = mkv(1, 0, 0, 1, 32'h0,  5'd0,  0,  0, 1, 0, 32'h0,  5'd0,  0);
        tv[12] = mkv(1, 0, 1, 0, 32'h11, 5'd11, 1,  1, 1, 1, 32'h11, 5'd11, 0);
        tv[13] = mkv(1, 0, 1, 0, 32'h12, 5'd12, 1,  1, 0, 1, 32'h11, 5'd11, 0);
        tv[14] = mkv(1, 1, 1, 1, 32'h99, 5'd9,  1,  0, 1, 0, 32'h0,  5'd0,  0);
        tv[15] = mkv(1, 0, 0, 1, 32'h0,  5'd0,  0,  0, 1, 0, 32'h0,  5'd0,  0);
        tv[16] = mkv(1, 0, 0, 0, 32'h77, 5'd4,  1,  0, 1, 0, 32'h0,  5'd0,  0);
        tv[17] = mkv(1, 0, 0, 1, 32'h77, 5'd4,  1,  0, 1, 0, 32'h0,  5'd0,  0);
        tv[18] = mkv(1, 1, 1, 1, 32'h33, 5'd6,  1,  0, 1, 0, 32'h0,  5'd0,  0);
        tv[19] = mkv(1, 0, 0, 1, 32'h0,  5'd0,  0,  0, 1, 0, 32'h0,  5'd0,  0);
        tv[20] = mkv(1, 0, 1, 0, 32'h44, 5'd8,  1,  1, 1, 1, 32'h44, 5'd8,  0);
        tv[21] = mkv(0, 1, 1, 1, 32'h66, 5'd2,  1,  0, 1, 0, 32'h0,  5'd0,  1);

        for (int i = 0; i < 22; i++) begin
            cycle(tv[i].rst, tv[i].fl, tv[i].iv, tv[i].ordy, mkpl(tv[i].alu, tv[i].rd, tv[i].rw));
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].e_ov});
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].e_ir});
            chk($sformatf("v%0d_reg_write_w", i), {31'd0, reg_write_w}, {31'd0, tv[i].e_rw});
            if (tv[i].e_ov || tv[i].zchk) begin
                chk($sformatf("v%0d_alu_result_w", i), alu_result_w, tv[i].e_alu);
                chk($sformatf("v%0d_rd_w", i), {27'd0, rd_w}, {27'd0, tv[i].e_rd});
            end
            if (tv[i].zchk) begin
                chk($sformatf("v%0d_read_data_zero", i), read_data_w, 32'd0);
                chk($sformatf("v%0d_pc_plus4_zero", i), pc_plus4_w, 32'd0);
            end
        end

        // Sustained stall: four cycles held with out_ready low, payload must not move.
        cycle(1, 0, 1, 0, mkpl(32'hABCD, 5'd13, 1));
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, mkpl(32'hFFFF_0000 + i, 5'd20, 1));
            chk("stall_hold_rd_w", {27'd0, rd_w}, 32'd13);
        end
        cycle(1, 0, 0, 1, mkpl(32'h0, 5'd0, 0));
        chk("stall_release_empty", {31'd0, out_valid}, 32'd0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_fl, r_iv, r_or;
            r_rst = ($urandom_range(0, 199) != 0);
            r_fl  = ($urandom_range(0, 29) == 0);
            r_iv  = ($urandom_range(0, 9) < 6);
            r_or  = ($urandom_range(0, 9) < 6);
            cycle(r_rst, r_fl, r_iv, r_or, mkpl($urandom, 5'($urandom), 1'($urandom)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
